// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_subtractor                                            |
// | Description : Bit-serial LSB-first subtractor (a - b - borrow) built from  |
// |               one full-subtractor cell, with start/ready/done handshake.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             borrow_in,
    output logic             ready_out,
    output logic             done_out,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             ovf_out,
    output logic             zero_out
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic               br_q, br_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;

    logic               w_a;
    logic               w_b;
    logic               w_d;
    logic               w_br_next;
    logic [WIDTH-1:0]   w_sh_next;

    // Single full-subtractor cell operating on the current LSBs.
    assign w_a       = a_q[0];
    assign w_b       = b_q[0];
    assign w_d       = w_a ^ w_b ^ br_q;
    assign w_br_next = (~w_a & w_b) | (~(w_a ^ w_b) & br_q);
    assign w_sh_next = {w_d, sh_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sh_d     = sh_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    br_d    = borrow_in;
                    sh_d    = '0;
                    cnt_d   = '0;
                    a_msb_d = a_in[WIDTH-1];
                    b_msb_d = b_in[WIDTH-1];
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sh_d  = w_sh_next;
                br_d  = w_br_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    // w_d here is the result MSB, which decides signed overflow.
                    diff_d   = w_sh_next;
                    borrow_d = w_br_next;
                    ovf_d    = (a_msb_q != b_msb_q) && (w_d != a_msb_q);
                    zero_d   = (w_sh_next == '0);
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign ready_out  = (state_q == IDLE);
    assign done_out   = done_q;
    assign diff_out   = diff_q;
    assign borrow_out = borrow_q;
    assign ovf_out    = ovf_q;
    assign zero_out   = zero_q;

endmodule
`default_nettype wire
